// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the SRAM arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // SRAM strobes are active-low
    localparam logic RAM_ENABLE  = 1'b0;
    localparam logic RAM_DISABLE = 1'b1;

    localparam int MEM_ADDR_W = 18;
    localparam int MEM_DATA_W = 16;

    // Width of a port index; a single-port arbiter still needs one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - combinational one-hot grant from requests, pointer and mode
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE   = 1,
    parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PTR_W-1:0]     o_grant_idx,
    output logic                 o_valid
);

    // Scan from the search start (last grant + 1, or port 0 in fixed mode); first requester wins
    always_comb begin
        int w_cand;
        w_cand      = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (RR_MODE != 0) begin
                w_cand = (int'(i_ptr) + 1 + i) % NUM_PORTS;
            end else begin
                w_cand = i;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_grant_idx      = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port SRAM arbiter with strobe sequencing and wait states
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [NUM_PORTS-1:0]        ack_o,
    output logic [NUM_PORTS-1:0]        pause_o,
    output logic                        ram_en_o,
    output logic                        ram_oe_o,
    output logic                        ram_we_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [DATA_W-1:0]           ram_wdata_o,
    output logic                        ram_wdata_oe_o,
    input  logic [DATA_W-1:0]           ram_rdata_i
);

    localparam int PTR_W = ptr_width(NUM_PORTS);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("mem_arbiter: WAIT_CYCLES must be at least 1");
    end

    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_wr;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [NUM_PORTS-1:0]   r_ack;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_en;
    logic                   r_oe;
    logic                   r_we;
    logic                   r_wdata_oe;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;

    logic [NUM_PORTS-1:0]   w_arb_req;
    logic [NUM_PORTS-1:0]   w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_start;

    // The port being acked in DONE still shows its old request; hide it so it is not re-served
    assign w_arb_req = (r_state == ST_DONE) ? (req_i & ~r_ack) : req_i;
    assign w_start   = w_grant_valid && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    mem_arbiter_rr #(
        .NUM_PORTS (NUM_PORTS),
        .RR_MODE   (RR_MODE),
        .PTR_W     (PTR_W)
    ) u_rr (
        .i_req       (w_arb_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_valid)
    );

    // Access sequencer: latch the winner, walk SETUP/ACCESS/DONE, drive registered strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PTR_W'(NUM_PORTS - 1);
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_en       <= RAM_DISABLE;
            r_oe       <= RAM_DISABLE;
            r_we       <= RAM_DISABLE;
            r_wdata_oe <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_ack <= '0;
            if (w_start) begin
                r_state    <= ST_SETUP;
                r_ptr      <= w_grant_idx;
                r_grant    <= w_grant;
                r_wr       <= we_i[w_grant_idx];
                r_addr     <= addr_i[w_grant_idx*ADDR_W +: ADDR_W];
                r_wdata    <= wdata_i[w_grant_idx*DATA_W +: DATA_W];
                r_en       <= RAM_ENABLE;
                r_oe       <= we_i[w_grant_idx] ? RAM_DISABLE : RAM_ENABLE;
                r_wdata_oe <= we_i[w_grant_idx];
            end else begin
                case (r_state)
                    ST_SETUP: begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        if (r_wr) begin
                            r_we <= RAM_ENABLE;
                        end
                    end
                    ST_ACCESS: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_ack   <= r_grant;
                            r_en    <= RAM_DISABLE;
                            r_oe    <= RAM_DISABLE;
                            r_we    <= RAM_DISABLE;
                            if (!r_wr) begin
                                r_rdata <= ram_rdata_i;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state    <= ST_IDLE;
                        r_wdata_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rdata_o        = r_rdata;
    assign ack_o          = r_ack;
    assign pause_o        = req_i & ~r_ack;
    assign ram_en_o       = r_en;
    assign ram_oe_o       = r_oe;
    assign ram_we_o       = r_we;
    assign ram_addr_o     = r_addr;
    assign ram_wdata_o    = r_wdata;
    assign ram_wdata_oe_o = r_wdata_oe;

endmodule
